status_flag_controller: RTL and testbench
=========================================

Name: status_flag_controller

Overview:
- Sequences every write to the 6502 processor status (P) register: ALU flag updates with per-flag enables, explicit set/clear instructions, PHP/BRK pushes and PLP/RTI pulls over a req/ack memory handshake.
- Owns the flag state and arbitrates between these sources; sits between the instruction decoder/ALU and the stack memory port.
- Supersedes direct loads of the 4-flag status register; adds D and I, masked updates and stack transfer.

Parameters:
- IRQ_MASK_RESET, 1, reset value of the I flag.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  apply ALU flag results this cycle
- alu_mask  in  4  per-flag enable {N,V,Z,C}
- alu_flags  in  4  new values {N,V,Z,C}
- flag_op_valid  in  1  apply explicit flag op this cycle
- flag_op  in  3  0 CLC, 1 SEC, 2 CLI, 3 SEI, 4 CLV, 5 CLD, 6 SED, 7 no-op
- push_start  in  1  begin push of P (PHP/BRK/IRQ)
- push_brk  in  1  B bit value written with the push
- pull_start  in  1  begin pull of P (PLP/RTI)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write (push), 0 = read (pull)
- mem_wdata  out  8  pushed P byte
- mem_rdata  in  8  pulled byte, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion strobe
- busy  out  1  high whenever state != IDLE
- p_out  out  8  {N,V,1,0,D,I,Z,C}
- flag_negative, flag_overflow, flag_decimal, flag_irq_disable, flag_zero, flag_carry  out  1 each  individual flags

Behaviour:
- Reset: N=V=D=Z=C=0, I=IRQ_MASK_RESET, state IDLE, mem_req=0, mem_we=0, mem_wdata=0x00, busy=0. Reset mid-transaction aborts it immediately; no flag commit.
- All flag updates take effect on the clock edge after the request. Outputs are registered; zero added latency.
- ALU update: for each bit i with alu_mask[i]=1, the flag takes alu_flags[i]. Masked-off flags hold.
- Flag op: overlays the ALU update in the same cycle. On a conflict (e.g. SEC with C masked in), the flag op wins.
- FSM states:
  - IDLE:
    - pull_start=1 -> PULL. pull_start wins over a simultaneous push_start, which is dropped.
    - else push_start=1 -> PUSH.
  - PUSH:
    - On entry, mem_wdata captures {N,V,1,push_brk,D,I,Z,C} from the pre-update flags of the start cycle.
    - mem_req=1, mem_we=1 while in PUSH.
    - mem_ack -> IDLE; mem_req drops the next cycle.
    - ALU and flag-op updates continue to apply during PUSH. The snapshot is not altered.
  - PULL:
    - mem_req=1, mem_we=0.
    - On mem_ack, N,V,D,I,Z,C load from mem_rdata bits 7,6,3,2,1,0. Bits 5 and 4 are ignored. State -> IDLE.
    - ALU and flag-op requests arriving while in PULL (including the ack cycle) are discarded.
- push_start or pull_start while busy=1 is ignored; there is no queueing.
- Start requests accepted in IDLE also apply any same-cycle ALU/flag-op update. For a push, the snapshot excludes that update.
- mem_ack outside PUSH/PULL is ignored.
- p_out bit5 is always 1 and bit4 is always 0.

Decomposition:
- Shared package cpu_pkg:
  - flag_op_e enum (CLC..SED, NOP)
  - P bit-index constants (P_N=7, P_V=6, P_U=5, P_B=4, P_D=3, P_I=2, P_Z=1, P_C=0)
  - stack_fsm_e {IDLE, PUSH, PULL}
- No sub-module: the flag-merge logic stays combinational inside the block.

Test Plan:
- Reset, then idle -> p_out=0x24, busy=0, mem_req=0; with IRQ_MASK_RESET=0, p_out=0x20.
- alu_valid with mask=0b1011, flags=0b1111, plus flag_op=CLC in the same cycle -> next cycle N=1, V=0, Z=1, C=0.
- Flags N=1, C=1; push_start with push_brk=1, plus alu_valid mask=0b0001, flags=0 in the same cycle -> mem_wdata=0xB1, C=0 next cycle. Ack after 3 cycles -> busy drops, mem_req low the cycle after ack.
- pull_start, mem_rdata=0xFF acked after 2 cycles, SEC/CLV issued during PULL -> p_out=0xEF. Issued ops are lost; bits 5 and 4 are ignored.
- push_start and pull_start together in IDLE -> PULL entered, mem_we=0, no push occurs. A second push_start while busy -> ignored.
- Reset asserted during PULL before ack -> state IDLE, mem_req=0 next cycle, flags=0x24. A late mem_ack is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 6502 processor status (P) register logic.
//   flag_op_e    : explicit flag instructions carried on flag_op (3 bits)
//   stack_fsm_e  : states of the push/pull sequencer
//   P_*          : bit positions inside the P byte {N,V,1,B,D,I,Z,C}
//   pack_p()     : assembles a P byte from individual flag values
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_CLC = 3'd0,
        OP_SEC = 3'd1,
        OP_CLI = 3'd2,
        OP_SEI = 3'd3,
        OP_CLV = 3'd4,
        OP_CLD = 3'd5,
        OP_SED = 3'd6,
        OP_NOP = 3'd7
    } flag_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        PULL = 2'd2
    } stack_fsm_e;

    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_U = 5;
    localparam int P_B = 4;
    localparam int P_D = 3;
    localparam int P_I = 2;
    localparam int P_Z = 1;
    localparam int P_C = 0;

    // Bit 5 of P reads as 1 and bit 4 (B) only exists in pushed copies.
    localparam logic [7:0] P_U_SET  = 8'h20;
    localparam logic [7:0] P_B_KEEP = 8'hEF;

    function automatic logic [7:0] pack_p(
        input logic n,
        input logic v,
        input logic b,
        input logic d,
        input logic i,
        input logic z,
        input logic c
    );
        return {n, v, 1'b1, b, d, i, z, c};
    endfunction

endpackage

// File: rtl/status_flag_controller_if.sv
// ---------------------------------------------------------------------------
// status_flag_controller_if
// Stack memory port used to push and pull the P register.
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = write (push), 0 = read (pull)
//   mem_wdata : byte written on a push
//   mem_rdata : byte returned on a pull, valid with mem_ack
//   mem_ack   : one-cycle completion strobe from memory
// master = status flag controller, slave = stack memory.
// ---------------------------------------------------------------------------
interface status_flag_controller_if;

    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/status_flag_controller.sv
// ---------------------------------------------------------------------------
// status_flag_controller
// Owns the 6502 P register and sequences every write to it: masked ALU flag
// updates, explicit set/clear instructions, and push/pull of P over the
// stack memory handshake.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   alu_valid         : apply alu_flags under alu_mask ({N,V,Z,C})
//   flag_op_valid     : apply flag_op (CLC,SEC,CLI,SEI,CLV,CLD,SED,NOP)
//   push_start        : start a push of P, push_brk gives the B bit
//   pull_start        : start a pull of P
//   mem_if            : stack memory request/ack port (master side)
//   busy              : a push or pull is in progress
//   p_out             : {N,V,1,0,D,I,Z,C}
//   flag_*            : individual flag outputs
// ---------------------------------------------------------------------------
module status_flag_controller
    import cpu_pkg::*;
#(
    parameter bit IRQ_MASK_RESET = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             alu_valid,
    input  logic [3:0]                       alu_mask,
    input  logic [3:0]                       alu_flags,
    input  logic                             flag_op_valid,
    input  logic [2:0]                       flag_op,
    input  logic                             push_start,
    input  logic                             push_brk,
    input  logic                             pull_start,
    status_flag_controller_if.master         mem_if,
    output logic                             busy,
    output logic [7:0]                       p_out,
    output logic                             flag_negative,
    output logic                             flag_overflow,
    output logic                             flag_decimal,
    output logic                             flag_irq_disable,
    output logic                             flag_zero,
    output logic                             flag_carry
);

    localparam logic [7:0] P_RESET = pack_p(1'b0, 1'b0, 1'b0, 1'b0,
                                            IRQ_MASK_RESET, 1'b0, 1'b0);

    stack_fsm_e state_reg, state_next;
    // Full P byte; bit 5 stays 1 and bit 4 stays 0 because no path ever
    // writes them with anything else.
    logic [7:0] p_reg, p_next;
    logic [7:0] wdata_reg, wdata_next;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            p_reg     <= P_RESET;
            wdata_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            p_reg     <= p_next;
            wdata_reg <= wdata_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and flag merge
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        p_next     = p_reg;
        wdata_next = wdata_reg;

        if (state_reg == PULL) begin
            // A pull owns the register: ALU and flag-op requests are dropped
            // for its whole duration, including the ack cycle.
            if (mem_if.mem_ack) begin
                p_next     = (mem_if.mem_rdata | P_U_SET) & P_B_KEEP;
                state_next = IDLE;
            end
        end else begin
            if (alu_valid) begin
                if (alu_mask[3]) p_next[P_N] = alu_flags[3];
                if (alu_mask[2]) p_next[P_V] = alu_flags[2];
                if (alu_mask[1]) p_next[P_Z] = alu_flags[1];
                if (alu_mask[0]) p_next[P_C] = alu_flags[0];
            end

            // Applied after the ALU merge so an explicit op wins a conflict.
            if (flag_op_valid) begin
                case (flag_op_e'(flag_op))
                    OP_CLC:  p_next[P_C] = 1'b0;
                    OP_SEC:  p_next[P_C] = 1'b1;
                    OP_CLI:  p_next[P_I] = 1'b0;
                    OP_SEI:  p_next[P_I] = 1'b1;
                    OP_CLV:  p_next[P_V] = 1'b0;
                    OP_CLD:  p_next[P_D] = 1'b0;
                    OP_SED:  p_next[P_D] = 1'b1;
                    default: ;
                endcase
            end

            if (state_reg == IDLE) begin
                if (pull_start) begin
                    state_next = PULL;
                end else if (push_start) begin
                    state_next = PUSH;
                    // Snapshot from p_reg, so the same-cycle update is not in it.
                    wdata_next = pack_p(p_reg[P_N], p_reg[P_V], push_brk,
                                        p_reg[P_D], p_reg[P_I], p_reg[P_Z],
                                        p_reg[P_C]);
                end
            end else if (mem_if.mem_ack) begin
                state_next = IDLE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all decoded from registers)
    // -----------------------------------------------------------------------
    assign busy             = (state_reg != IDLE);
    assign mem_if.mem_req   = (state_reg != IDLE);
    assign mem_if.mem_we    = (state_reg == PUSH);
    assign mem_if.mem_wdata = wdata_reg;

    assign p_out            = p_reg;
    assign flag_negative    = p_reg[P_N];
    assign flag_overflow    = p_reg[P_V];
    assign flag_decimal     = p_reg[P_D];
    assign flag_irq_disable = p_reg[P_I];
    assign flag_zero        = p_reg[P_Z];
    assign flag_carry       = p_reg[P_C];

endmodule

// File: tb/tb_status_flag_controller.sv
// ---------------------------------------------------------------------------
// tb_status_flag_controller
// Self-checking bench for status_flag_controller. Expected P values and
// pushed bytes are pushed to scoreboard queues when stimulus is driven and
// popped when the DUT output is sampled, one cycle later.
// ---------------------------------------------------------------------------
module tb_status_flag_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid;
    logic [3:0] alu_mask;
    logic [3:0] alu_flags;
    logic       flag_op_valid;
    logic [2:0] flag_op;
    logic       push_start;
    logic       push_brk;
    logic       pull_start;

    logic       busy, busy_b;
    logic [7:0] p_out, p_out_b;
    logic       fn, fv, fd, fi, fz, fc;
    logic       fn_b, fv_b, fd_b, fi_b, fz_b, fc_b;

    status_flag_controller_if mem_bus();
    status_flag_controller_if mem_bus_b();

    always #5 clk = ~clk;

    status_flag_controller #(.IRQ_MASK_RESET(1'b1)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_mask(alu_mask), .alu_flags(alu_flags),
        .flag_op_valid(flag_op_valid), .flag_op(flag_op),
        .push_start(push_start), .push_brk(push_brk), .pull_start(pull_start),
        .mem_if(mem_bus), .busy(busy), .p_out(p_out),
        .flag_negative(fn), .flag_overflow(fv), .flag_decimal(fd),
        .flag_irq_disable(fi), .flag_zero(fz), .flag_carry(fc)
    );

    status_flag_controller #(.IRQ_MASK_RESET(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_mask(alu_mask), .alu_flags(alu_flags),
        .flag_op_valid(flag_op_valid), .flag_op(flag_op),
        .push_start(push_start), .push_brk(push_brk), .pull_start(pull_start),
        .mem_if(mem_bus_b), .busy(busy_b), .p_out(p_out_b),
        .flag_negative(fn_b), .flag_overflow(fv_b), .flag_decimal(fd_b),
        .flag_irq_disable(fi_b), .flag_zero(fz_b), .flag_carry(fc_b)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_p[$];
    logic [7:0] sb_w[$];
    logic [7:0] model_p;
    logic [7:0] exp_v;
    logic [7:0] snap;

    // Reference flag model: ALU merge first, explicit op on top.
    function automatic logic [7:0] model_apply(
        input logic [7:0] p, input logic av, input logic [3:0] m,
        input logic [3:0] f, input logic ov, input logic [2:0] op);
        logic [7:0] r;
        r = p;
        if (av) begin
            if (m[3]) r[7] = f[3];
            if (m[2]) r[6] = f[2];
            if (m[1]) r[1] = f[1];
            if (m[0]) r[0] = f[0];
        end
        if (ov) begin
            case (op)
                3'd0: r[0] = 1'b0;
                3'd1: r[0] = 1'b1;
                3'd2: r[2] = 1'b0;
                3'd3: r[2] = 1'b1;
                3'd4: r[6] = 1'b0;
                3'd5: r[3] = 1'b0;
                3'd6: r[3] = 1'b1;
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0; alu_mask = 4'h0; alu_flags = 4'h0;
        flag_op_valid = 1'b0; flag_op = 3'd7;
        push_start = 1'b0; push_brk = 1'b0; pull_start = 1'b0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 8'h00;
    endtask

    // Drive an ALU/flag-op update and record its expected result.
    task automatic drive_update(input logic av, input logic [3:0] m,
                                input logic [3:0] f, input logic ov,
                                input logic [2:0] op);
        alu_valid = av; alu_mask = m; alu_flags = f;
        flag_op_valid = ov; flag_op = op;
        model_p = model_apply(model_p, av, m, f, ov, op);
        sb_p.push_back(model_p);
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_p = 8'h24;
        sb_p.push_back(model_p);
        exp_v = sb_p.pop_front();
        checks++; if (p_out !== exp_v) begin errors++; $display("FAIL reset_p_out: got %h expected %h", p_out, exp_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_bus.mem_req); end
        checks++; if (mem_bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_bus.mem_we); end
        checks++; if (mem_bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 00", mem_bus.mem_wdata); end
        checks++; if (fi !== 1'b1) begin errors++; $display("FAIL reset_irq_flag: got %b expected 1", fi); end
        checks++; if (p_out_b !== 8'h20) begin errors++; $display("FAIL reset_p_out_irq0: got %h expected 20", p_out_b); end
        checks++; if (fi_b !== 1'b0) begin errors++; $display("FAIL reset_irq_flag_irq0: got %b expected 0", fi_b); end
        $display("reset: p_out=%h p_out_irq0=%h busy=%b", p_out, p_out_b, busy);
    endtask

    task automatic test_alu_flag_op;
        drive_update(1'b1, 4'b1011, 4'b1111, 1'b1, 3'd0);   // CLC overrides C
        tick();
        idle_inputs();
        exp_v = sb_p.pop_front();
        checks++; if (p_out !== exp_v) begin errors++; $display("FAIL alu_clc_p_out: got %h expected %h", p_out, exp_v); end
        checks++; if ({fn, fv, fz, fc} !== 4'b1010) begin errors++; $display("FAIL alu_clc_nvzc: got %b expected 1010", {fn, fv, fz, fc}); end
        $display("alu+clc: p_out=%h", p_out);
    endtask

    task automatic test_push;
        // Establish N=1, C=1, everything else clear.
        drive_update(1'b1, 4'b1111, 4'b1001, 1'b1, 3'd2);
        tick();
        idle_inputs();
        exp_v = sb_p.pop_front();
        checks++; if (p_out !== exp_v) begin errors++; $display("FAIL push_setup_p_out: got %h expected %h", p_out, exp_v); end

        // Push with B=1 and a same-cycle ALU clear of C.
        snap = {model_p[7:5], 1'b1, model_p[3:0]};
        sb_w.push_back(snap);
        push_start = 1'b1; push_brk = 1'b1;
        drive_update(1'b1, 4'b0001, 4'b0000, 1'b0, 3'd7);
        tick();
        idle_inputs();
        exp_v = sb_w.pop_front();
        checks++; if (mem_bus.mem_wdata !== exp_v) begin errors++; $display("FAIL push_wdata: got %h expected %h", mem_bus.mem_wdata, exp_v); end
        checks++; if (mem_bus.mem_wdata !== 8'hB1) begin errors++; $display("FAIL push_wdata_const: got %h expected b1", mem_bus.mem_wdata); end
        exp_v = sb_p.pop_front();
        checks++; if (p_out !== exp_v) begin errors++; $display("FAIL push_same_cycle_alu: got %h expected %h", p_out, exp_v); end
        checks++; if ({busy, mem_bus.mem_req, mem_bus.mem_we} !== 3'b111) begin errors++; $display("FAIL push_handshake: got %b expected 111", {busy, mem_bus.mem_req, mem_bus.mem_we}); end

        // Updates still apply during PUSH; the snapshot stays put.
        drive_update(1'b0, 4'h0, 4'h0, 1'b1, 3'd1);           // SEC
        tick();
        idle_inputs();
        exp_v = sb_p.pop_front();
        checks++; if (p_out !== exp_v) begin errors++; $display("FAIL push_update_during: got %h expected %h", p_out, exp_v); end
        checks++; if (mem_bus.mem_wdata !== snap) begin errors++; $display("FAIL push_snapshot_hold: got %h expected %h", mem_bus.mem_wdata, snap); end
        tick();
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL push_req_held: got %b expected 1", mem_bus.mem_req); end
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        checks++; if ({busy, mem_bus.mem_req} !== 2'b00) begin errors++; $display("FAIL push_after_ack: got %b expected 00", {busy, mem_bus.mem_req}); end
        $display("push: wdata=%h p_out=%h busy=%b", mem_bus.mem_wdata, p_out, busy);
    endtask

    task automatic test_pull;
        pull_start = 1'b1;
        tick();
        idle_inputs();
        checks++; if ({busy, mem_bus.mem_req, mem_bus.mem_we} !== 3'b110) begin errors++; $display("FAIL pull_handshake: got %b expected 110", {busy, mem_bus.mem_req, mem_bus.mem_we}); end
        // Discarded: ALU clear of everything plus CLC.
        alu_valid = 1'b1; alu_mask = 4'hF; alu_flags = 4'h0;
        flag_op_valid = 1'b1; flag_op = 3'd0;
        tick();
        idle_inputs();
        checks++; if (p_out !== model_p) begin errors++; $display("FAIL pull_ignores_update: got %h expected %h", p_out, model_p); end
        // Ack with a CLV in the same cycle; CLV must be lost.
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 8'hFF;
        flag_op_valid = 1'b1; flag_op = 3'd4;
        model_p = 8'hEF;
        sb_p.push_back(model_p);
        tick();
        idle_inputs();
        exp_v = sb_p.pop_front();
        checks++; if (p_out !== exp_v) begin errors++; $display("FAIL pull_load: got %h expected %h", p_out, exp_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pull_busy_drop: got %b expected 0", busy); end
        $display("pull: p_out=%h busy=%b", p_out, busy);
    endtask

    task automatic test_collision;
        snap = mem_bus.mem_wdata;
        push_start = 1'b1; pull_start = 1'b1; push_brk = 1'b0;
        tick();
        idle_inputs();
        checks++; if ({mem_bus.mem_req, mem_bus.mem_we} !== 2'b10) begin errors++; $display("FAIL collide_pull_wins: got %b expected 10", {mem_bus.mem_req, mem_bus.mem_we}); end
        push_start = 1'b1;                                      // ignored while busy
        tick();
        idle_inputs();
        checks++; if ({busy, mem_bus.mem_we} !== 2'b10) begin errors++; $display("FAIL busy_push_ignored: got %b expected 10", {busy, mem_bus.mem_we}); end
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 8'h00;
        model_p = 8'h20;
        sb_p.push_back(model_p);
        tick();
        idle_inputs();
        exp_v = sb_p.pop_front();
        checks++; if (p_out !== exp_v) begin errors++; $display("FAIL collide_pull_load: got %h expected %h", p_out, exp_v); end
        tick();
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL collide_no_push: got %b expected 0", mem_bus.mem_req); end
        checks++; if (mem_bus.mem_wdata !== snap) begin errors++; $display("FAIL collide_wdata_untouched: got %h expected %h", mem_bus.mem_wdata, snap); end
        $display("collision: p_out=%h mem_req=%b", p_out, mem_bus.mem_req);
    endtask

    task automatic test_reset_mid_pull;
        pull_start = 1'b1;
        tick();
        idle_inputs();
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL midpull_req: got %b expected 1", mem_bus.mem_req); end
        reset = 1'b1;
        model_p = 8'h24;
        sb_p.push_back(model_p);
        tick();
        reset = 1'b0;
        exp_v = sb_p.pop_front();
        checks++; if (p_out !== exp_v) begin errors++; $display("FAIL midpull_reset_p: got %h expected %h", p_out, exp_v); end
        checks++; if ({busy, mem_bus.mem_req} !== 2'b00) begin errors++; $display("FAIL midpull_reset_idle: got %b expected 00", {busy, mem_bus.mem_req}); end
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 8'hC3;     // late ack
        sb_p.push_back(model_p);
        tick();
        idle_inputs();
        exp_v = sb_p.pop_front();
        checks++; if (p_out !== exp_v) begin errors++; $display("FAIL late_ack_ignored: got %h expected %h", p_out, exp_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL late_ack_busy: got %b expected 0", busy); end
        $display("reset mid pull: p_out=%h busy=%b", p_out, busy);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 24; k++) begin
            drive_update(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                         1'($urandom_range(0, 1)), 3'($urandom));
            mem_bus.mem_ack = 1'($urandom_range(0, 1));       // stray acks in IDLE
            mem_bus.mem_rdata = 8'($urandom);
            tick();
            exp_v = sb_p.pop_front();
            checks++; if (p_out !== exp_v) begin errors++; $display("FAIL b2b_p_out[%0d]: got %h expected %h", k, p_out, exp_v); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy[%0d]: got %b expected 0", k, busy); end
            $display("b2b %0d: p_out=%h", k, p_out);
        end
        idle_inputs();
    endtask

    initial begin
        mem_bus_b.mem_ack = 1'b0;
        mem_bus_b.mem_rdata = 8'h00;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_flag_op();
        test_push();
        test_pull();
        test_collision();
        test_reset_mid_pull();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
